alu_serial_ctrl: RTL and testbench
==================================

Name: alu_serial_ctrl

Overview:
Bit-serial execute-stage sequencer that drives one external alu_bit_slice instance.
- Accepts a WIDTH-bit operand pair and a 3-bit function code.
- Presents one operand bit pair per cycle to the slice, LSB first.
- Holds the slice's carry-out in a flop and feeds it back as the next carry-in.
- Shifts the slice's f output into a result register and returns the result, carry flag and zero flag to the downstream stage over a valid/ready handshake.

Parameters:
WIDTH, 8, operand/result width in bits (>=2).
CNT_W, $clog2(WIDTH)+1, bit counter width (derived, do not override).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand/function request valid.
in_ready  output  1  controller can accept a request.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_func  input  3  function code, slice encoding: 000 A+B, 001 A+~B+1 (subtract), 010 ~A, 011 ~B, 100 A|B, 101 A|~B, 110 A&B, 111 A&~B.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
out_result  output  WIDTH  result word.
out_carry  output  1  final carry-out; arithmetic functions only, else 0.
out_zero  output  1  out_result == 0.
out_ovf  output  1  signed overflow (see Optional Feature).
slice_c  output  3  function code to slice.
slice_a  output  1  current A bit to slice.
slice_b  output  1  current B bit to slice.
slice_ci  output  1  carry-in to slice.
slice_f  input  1  slice result bit.
slice_co  input  1  slice carry-out.

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1, out_valid=0; out_result, out_carry, out_zero, out_ovf=0; slice_c, slice_a, slice_b, slice_ci=0; all shift registers, the counter and the carry flop cleared. Reset mid-operation abandons the request; no partial result is ever presented.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture in_a, in_b, in_func into shift regs a_sh, b_sh and func_q; clear cnt; load carry_q = in_func[0] if in_func[2:1]==00, else 0; go to RUN.
  - RUN: in_ready=0. slice_a=a_sh[0], slice_b=b_sh[0], slice_ci=carry_q, slice_c=func_q. All slice_* outputs are register-driven; no combinational path from inputs to slice_* outputs. Each edge:
    - r_sh <= {slice_f, r_sh[WIDTH-1:1]}
    - a_sh and b_sh shift right 1
    - carry_q <= slice_co
    - cnt++
  - RUN exit: on the edge where cnt==WIDTH-1, capture out_result={slice_f, r_sh[WIDTH-1:1]}; out_carry=slice_co if func_q[2:1]==00, else 0; out_zero from the captured word; go to DONE.
  - DONE: out_valid=1; outputs held stable while out_ready=0 (arbitrary stall length). On out_ready, go to IDLE next edge; out_valid drops. No new request is accepted in DONE.
- slice_* outputs are 0 in IDLE and DONE.
- Latency: request accepted at edge T; out_valid high after edge T+WIDTH. Throughput: one op per WIDTH+2 cycles minimum.
- Subtract carry convention: out_carry=1 means no borrow.
- Stray in_valid outside IDLE is ignored; the request is not captured.

Optional Feature:
ALU_SERIAL_OVF_EN
- Defined: for arithmetic functions (func_q[2:1]==00), out_ovf = slice_ci XOR slice_co sampled on the MSB cycle (carry into MSB vs carry out of MSB), captured with out_result. Forced 0 for logic functions. Cleared by reset.
- Not defined: out_ovf tied to 0. No extra flops are synthesised. The port remains so instantiations are unchanged.

Test Plan:
All scenarios use WIDTH=8 with a behavioural alu_bit_slice attached to the slice_* ports.
1. Add: func=000, A=0x35, B=0x4A -> result 0x7F, carry 0, zero 0; out_valid rises 8 cycles after the accept edge; slice_ci=0 on the first RUN cycle.
2. Subtract: func=001, A=0x10, B=0x01 -> 0x0F, carry 1. Then A=0x00, B=0x01 -> 0xFF, carry 0. Then A=0x22, B=0x22 -> 0x00, zero 1, carry 1.
3. Logic ops: func=111, A=0xF0, B=0x3C -> 0xC0, carry 0. Then func=010, A=0x00 -> 0xFF. Then func=100, A=0x00, B=0x00 -> 0x00, zero 1.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result, flags and out_valid stable; in_ready=0; in_valid pulses are ignored. Release -> in_ready=1 the next cycle.
5. Reset mid-run: assert rst_n=0 asynchronously after 3 RUN cycles -> all outputs 0 immediately, state IDLE. A new add 0x01+0x01 then returns 0x02.
6. Overflow (ALU_SERIAL_OVF_EN defined): func=000, 0x7F+0x01 -> 0x80, ovf 1, carry 0. func=001, 0x80-0x01 -> 0x7F, ovf 1. Same stimulus with the macro undefined -> ovf 0.

Source files
------------

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial execute-stage sequencer driving one external
// alu_bit_slice. Operands are fed LSB first, one bit pair per cycle, with the
// slice carry-out looped back through a flop. The result word, carry and zero
// flags are returned over a valid/ready handshake.
//
// Optional build macro: ALU_SERIAL_OVF_EN
//   defined   -> out_ovf reports signed overflow for arithmetic functions
//   undefined -> out_ovf is tied to 0 and no overflow flop exists
module alu_serial_ctrl #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_func,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_ovf,
    output logic [2:0]       slice_c,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_ci,
    input  logic             slice_f,
    input  logic             slice_co
);

    localparam int unsigned RW = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [RW-1:0]    r_sh_q, r_sh_d;
    logic [2:0]       func_q, func_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cflag_q, cflag_d;
    logic             zflag_q, zflag_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic             last_c;
    logic             arith_c;
    logic [WIDTH-1:0] r_cat_c;

    assign last_c  = (cnt_q == CNT_W'(WIDTH - 1));
    assign arith_c = (func_q[2:1] == 2'b00);
    // Incoming slice bit joined with the bits collected so far; on the final
    // cycle this is the complete result word.
    assign r_cat_c = {slice_f, r_sh_q};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (in_valid && in_ready_q) state_d = S_RUN;
            S_RUN:  if (last_c)                 state_d = S_DONE;
            S_DONE: if (out_ready)              state_d = S_IDLE;
            default:                            state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values; the operand/function/carry registers
    // are cleared on RUN exit so the slice outputs read 0 outside RUN.
    always_comb begin
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        r_sh_d      = r_sh_q;
        func_d      = func_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        cflag_d     = cflag_q;
        zflag_d     = zflag_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_sh_d     = in_a;
                    b_sh_d     = in_b;
                    func_d     = in_func;
                    r_sh_d     = '0;
                    cnt_d      = '0;
                    carry_d    = (in_func[2:1] == 2'b00) ? in_func[0] : 1'b0;
                    in_ready_d = 1'b0;
                end
            end
            S_RUN: begin
                r_sh_d  = r_cat_c[WIDTH-1:1];
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = slice_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_c) begin
                    result_d    = r_cat_c;
                    cflag_d     = arith_c ? slice_co : 1'b0;
                    zflag_d     = (r_cat_c == '0);
                    out_valid_d = 1'b1;
                    a_sh_d      = '0;
                    b_sh_d      = '0;
                    func_d      = '0;
                    carry_d     = 1'b0;
                    cnt_d       = '0;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            r_sh_q      <= '0;
            func_q      <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            cflag_q     <= 1'b0;
            zflag_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            r_sh_q      <= r_sh_d;
            func_q      <= func_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            cflag_q     <= cflag_d;
            zflag_q     <= zflag_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef ALU_SERIAL_OVF_EN
    logic ovf_q, ovf_d;

    // Signed overflow: carry into MSB differs from carry out of MSB
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == S_RUN && last_c) begin
            ovf_d = arith_c ? (carry_q ^ slice_co) : 1'b0;
        end
    end

    // Overflow flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign out_ovf = ovf_q;
`else
    assign out_ovf = 1'b0;
`endif

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = result_q;
    assign out_carry  = cflag_q;
    assign out_zero   = zflag_q;
    assign slice_c    = func_q;
    assign slice_a    = a_sh_q[0];
    assign slice_b    = b_sh_q[0];
    assign slice_ci   = carry_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Testbench for alu_serial_ctrl (WIDTH=8) with a behavioural bit slice.
// Expected results are queued by the stimulus and checked by a monitor.
module tb_alu_serial_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [2:0]   in_func = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_result;
    logic         out_carry;
    logic         out_zero;
    logic         out_ovf;
    logic [2:0]   slice_c;
    logic         slice_a;
    logic         slice_b;
    logic         slice_ci;
    logic         slice_f;
    logic         slice_co;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         v;
    } exp_t;

    exp_t sb[$];

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_func(in_func),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_carry(out_carry),
        .out_zero(out_zero), .out_ovf(out_ovf),
        .slice_c(slice_c), .slice_a(slice_a), .slice_b(slice_b),
        .slice_ci(slice_ci), .slice_f(slice_f), .slice_co(slice_co)
    );

    always #5 clk = ~clk;

    // Behavioural alu_bit_slice
    always_comb begin
        logic bb;
        bb       = slice_b;
        slice_f  = 1'b0;
        slice_co = 1'b0;
        case (slice_c)
            3'b000, 3'b001: begin
                bb       = (slice_c == 3'b001) ? ~slice_b : slice_b;
                slice_f  = slice_a ^ bb ^ slice_ci;
                slice_co = (slice_a & bb) | (slice_a & slice_ci) | (bb & slice_ci);
            end
            3'b010:  slice_f = ~slice_a;
            3'b011:  slice_f = ~slice_b;
            3'b100:  slice_f = slice_a | slice_b;
            3'b101:  slice_f = slice_a | ~slice_b;
            3'b110:  slice_f = slice_a & slice_b;
            default: slice_f = slice_a & ~slice_b;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every handshake-ready output is compared against the queue head
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", 32'(out_result), 32'(e.res));
                chk("carry",  32'(out_carry),  32'(e.c));
                chk("zero",   32'(out_zero),   32'(e.z));
                chk("ovf",    32'(out_ovf),    32'(e.v));
            end
        end
    end

    task automatic wait_ready();
        int i;
        for (i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (i == 50) chk("in_ready_timeout", 32'd0, 32'd1);
    endtask

    // Issue one request; expected ovf applies only when the feature is built
    task automatic run_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input logic ec, input logic ez,
                          input logic ev, input int stall);
        exp_t e;
        int   lat;
        e.res = er;
        e.c   = ec;
        e.z   = ez;
`ifdef ALU_SERIAL_OVF_EN
        e.v = ev;
`else
        e.v = 1'b0;
`endif
        wait_ready();
        in_func  = f;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("first_slice_ci", 32'(slice_ci), 32'(f == 3'b001));
        chk("first_slice_c",  32'(slice_c),  32'(f));
        chk("first_slice_a",  32'(slice_a),  32'(a[0]));
        chk("in_ready_run",   32'(in_ready), 32'd0);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        chk("latency", 32'(lat), 32'd8);
        for (int k = 0; k < stall; k++) begin
            in_valid = k[0];
            in_a     = 8'hAA;
            @(negedge clk);
            chk("stall_valid",  32'(out_valid),  32'd1);
            chk("stall_ready",  32'(in_ready),   32'd0);
            chk("stall_result", 32'(out_result), 32'(er));
            chk("stall_carry",  32'(out_carry),  32'(ec));
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("valid_drop",      32'(out_valid), 32'd0);
        chk("in_ready_return", 32'(in_ready),  32'd1);
    endtask

    initial begin
        #12;
        chk("rst_in_ready",  32'(in_ready),   32'd1);
        chk("rst_out_valid", 32'(out_valid),  32'd0);
        chk("rst_result",    32'(out_result), 32'd0);
        chk("rst_slice",     32'({slice_c, slice_a, slice_b, slice_ci}), 32'd0);
        chk("rst_ovf",       32'(out_ovf),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // add / subtract / logic (result, carry, zero, ovf)
        run_op(3'b000, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0, 1'b0, 0);
        run_op(3'b001, 8'h10, 8'h01, 8'h0F, 1'b1, 1'b0, 1'b0, 0);
        run_op(3'b001, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 0);
        run_op(3'b001, 8'h22, 8'h22, 8'h00, 1'b1, 1'b1, 1'b0, 0);
        run_op(3'b111, 8'hF0, 8'h3C, 8'hC0, 1'b0, 1'b0, 1'b0, 0);
        run_op(3'b010, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 0);
        run_op(3'b100, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 0);

        // backpressure with stray in_valid pulses: 0xFF+0x01 wraps to zero
        run_op(3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 5);

        // reset mid-run abandons the request
        wait_ready();
        in_func  = 3'b000;
        in_a     = 8'h55;
        in_b     = 8'h55;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready",  32'(in_ready),   32'd1);
        chk("midrst_out_valid", 32'(out_valid),  32'd0);
        chk("midrst_slice",     32'({slice_c, slice_a, slice_b, slice_ci}), 32'd0);
        chk("midrst_result",    32'(out_result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'b000, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 0);

        // signed overflow cases
        run_op(3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 0);
        run_op(3'b001, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1, 0);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
